// File: rtl/gp9001_host_resp.sv
// gp9001_host_resp
// Host-side command responder for a GP9001-style graphics controller.
// It accepts one CPU request per four-phase handshake (GP9001CS / GP9001ACK),
// decodes the highest-priority operation flag, and performs one of:
// register select, register write, VRAM pointer load, VRAM write, or a VRAM
// read with a fixed read latency.
//
// Ports
//   CLK, RESET             single clock, asynchronous active-high reset
//   GP9001CS               request, held high until GP9001ACK is seen
//   GP9001_OP_*            operation flags, sampled on request acceptance
//   GP9001DIN[15:0]        write data / register index / pointer value
//   GP9001DOUT[15:0]       last VRAM read data
//   GP9001ACK              completion acknowledge (high in DONE only)
//   REG_WE/ADDR/DATA       register write port to the GCU core
//   VRAM_ADDR/WDATA/WE/RD  VRAM port; VRAM_ADDR is the auto-increment pointer
//   VRAM_RDATA[15:0]       VRAM read data, valid RD_LAT cycles after VRAM_RD
module gp9001_host_resp #(
  parameter int RAM_AW = 14,
  parameter int RD_LAT = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              GP9001CS,
  input  logic              GP9001_OP_SELECT_REG,
  input  logic              GP9001_OP_WRITE_REG,
  input  logic              GP9001_OP_SET_RAM_PTR,
  input  logic              GP9001_OP_WRITE_RAM,
  input  logic              GP9001_OP_READ_RAM_H,
  input  logic              GP9001_OP_READ_RAM_L,
  input  logic [15:0]       GP9001DIN,
  output logic [15:0]       GP9001DOUT,
  output logic              GP9001ACK,
  output logic              REG_WE,
  output logic [7:0]        REG_ADDR,
  output logic [15:0]       REG_DATA,
  output logic [RAM_AW-1:0] VRAM_ADDR,
  output logic [15:0]       VRAM_WDATA,
  output logic              VRAM_WE,
  output logic              VRAM_RD,
  input  logic [15:0]       VRAM_RDATA
);

  typedef enum logic [1:0] {IDLE, EXEC, RD_WAIT, DONE} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_SEL, OP_WREG, OP_PTR, OP_WRAM, OP_RDH, OP_RDL} op_t;

  localparam logic [2:0]        RD_LAT_C = 3'(RD_LAT);
  localparam logic [RAM_AW-1:0] PTR_ONE  = {{(RAM_AW-1){1'b0}}, 1'b1};

  state_t              state_r;
  op_t                 op_r;
  op_t                 op_sel_s;
  logic [2:0]          cnt_r;
  logic [RAM_AW-1:0]   ptr_r;
  logic [15:0]         dout_r;
  logic                ack_r;
  logic                reg_we_r;
  logic [7:0]          reg_addr_r;
  logic [15:0]         reg_data_r;
  logic [15:0]         vram_wdata_r;
  logic                vram_we_r;
  logic                vram_rd_r;

  // Fixed-priority decode of the operation flags.
  always_comb begin
    op_sel_s = OP_NONE;
    if (GP9001_OP_SELECT_REG) begin
      op_sel_s = OP_SEL;
    end else if (GP9001_OP_WRITE_REG) begin
      op_sel_s = OP_WREG;
    end else if (GP9001_OP_SET_RAM_PTR) begin
      op_sel_s = OP_PTR;
    end else if (GP9001_OP_WRITE_RAM) begin
      op_sel_s = OP_WRAM;
    end else if (GP9001_OP_READ_RAM_H) begin
      op_sel_s = OP_RDH;
    end else if (GP9001_OP_READ_RAM_L) begin
      op_sel_s = OP_RDL;
    end else begin
      op_sel_s = OP_NONE;
    end
  end

  // Handshake FSM with all outputs registered.
  // DIN is consumed entirely on the accept edge, so strobes and their
  // address/data are already in place for the whole EXEC cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r      <= IDLE;
      op_r         <= OP_NONE;
      cnt_r        <= 3'd0;
      ptr_r        <= {RAM_AW{1'b0}};
      dout_r       <= 16'h0000;
      ack_r        <= 1'b0;
      reg_we_r     <= 1'b0;
      reg_addr_r   <= 8'h00;
      reg_data_r   <= 16'h0000;
      vram_wdata_r <= 16'h0000;
      vram_we_r    <= 1'b0;
      vram_rd_r    <= 1'b0;
    end else begin
      // Strobes last a single cycle unless re-armed below.
      reg_we_r  <= 1'b0;
      vram_we_r <= 1'b0;
      vram_rd_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (GP9001CS) begin
            op_r    <= op_sel_s;
            state_r <= EXEC;
            case (op_sel_s)
              OP_SEL:  reg_addr_r <= GP9001DIN[7:0];
              OP_WREG: begin
                reg_we_r   <= 1'b1;
                reg_data_r <= GP9001DIN;
              end
              OP_PTR:  ptr_r <= GP9001DIN[RAM_AW-1:0];
              OP_WRAM: begin
                vram_we_r    <= 1'b1;
                vram_wdata_r <= GP9001DIN;
              end
              OP_RDH, OP_RDL: vram_rd_r <= 1'b1;
              default: ;
            endcase
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          if ((op_r == OP_RDH) || (op_r == OP_RDL)) begin
            // One cycle since VRAM_RD has already elapsed on entry.
            cnt_r   <= 3'd1;
            state_r <= RD_WAIT;
          end else begin
            if (op_r == OP_WRAM) begin
              ptr_r <= ptr_r + PTR_ONE;
            end else begin
              ptr_r <= ptr_r;
            end
            ack_r   <= 1'b1;
            state_r <= DONE;
          end
        end
        RD_WAIT: begin
          if (cnt_r == RD_LAT_C) begin
            dout_r <= VRAM_RDATA;
            if (op_r == OP_RDL) begin
              ptr_r <= ptr_r + PTR_ONE;
            end else begin
              ptr_r <= ptr_r;
            end
            cnt_r   <= 3'd0;
            ack_r   <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
        DONE: begin
          // Leaving only on CS low enforces the four-phase handshake.
          if (!GP9001CS) begin
            ack_r   <= 1'b0;
            state_r <= IDLE;
          end else begin
            ack_r <= 1'b1;
          end
        end
        default: begin
          ack_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign GP9001DOUT = dout_r;
  assign GP9001ACK  = ack_r;
  assign REG_WE     = reg_we_r;
  assign REG_ADDR   = reg_addr_r;
  assign REG_DATA   = reg_data_r;
  assign VRAM_ADDR  = ptr_r;
  assign VRAM_WDATA = vram_wdata_r;
  assign VRAM_WE    = vram_we_r;
  assign VRAM_RD    = vram_rd_r;

endmodule

// File: doc/gp9001_host_resp.md
GP9001_HOST_RESP -- requirements
Module: gp9001_host_resp

Interface
REQ-001 Parameter RAM_AW, default 14: VRAM word-address width.
REQ-002 Parameter RD_LAT, default 2: VRAM read latency in CLK cycles, range 1..4.
REQ-003 CLK  input  1  single clock; all logic on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 GP9001CS  input  1  request from the CPU-side initiator; held high until ACK is seen, then dropped.
REQ-006 GP9001_OP_SELECT_REG, GP9001_OP_WRITE_REG, GP9001_OP_SET_RAM_PTR, GP9001_OP_WRITE_RAM, GP9001_OP_READ_RAM_H, GP9001_OP_READ_RAM_L  input  1 each  operation flags, stable while GP9001CS is high.
REQ-007 GP9001DIN  input  16  write data / register index / pointer value.
REQ-008 GP9001DOUT  output  16  read data, valid while GP9001ACK is high after a read.
REQ-009 GP9001ACK  output  1  completion acknowledge.
REQ-010 REG_WE  output  1  one-cycle register write strobe to the GCU core.
REQ-011 REG_ADDR  output  8  selected register index.
REQ-012 REG_DATA  output  16  register write data.
REQ-013 VRAM_ADDR  output  RAM_AW  VRAM word address.
REQ-014 VRAM_WDATA  output  16  VRAM write data.
REQ-015 VRAM_WE  output  1  one-cycle VRAM write strobe.
REQ-016 VRAM_RD  output  1  one-cycle VRAM read strobe.
REQ-017 VRAM_RDATA  input  16  VRAM read data, valid exactly RD_LAT cycles after VRAM_RD.

Function
REQ-018 The block SHALL implement four states: IDLE, EXEC, RD_WAIT, DONE.
REQ-019 IDLE->EXEC SHALL occur on the first cycle GP9001CS is high in IDLE; the op flags and GP9001DIN SHALL be captured that cycle.
REQ-020 With multiple flags set, the priority SHALL be SELECT_REG > WRITE_REG > SET_RAM_PTR > WRITE_RAM > READ_RAM_H > READ_RAM_L.
REQ-021 With no flag set, the block SHALL go EXEC->DONE with no side effect.
REQ-022 SELECT_REG: REG_ADDR <= DIN[7:0]; EXEC->DONE.
REQ-023 WRITE_REG: REG_WE high for exactly the EXEC cycle, with REG_ADDR unchanged and REG_DATA = DIN; EXEC->DONE.
REQ-024 SET_RAM_PTR: pointer <= DIN[RAM_AW-1:0]; EXEC->DONE.
REQ-025 WRITE_RAM: VRAM_WE high for exactly the EXEC cycle, with VRAM_ADDR = pointer and VRAM_WDATA = DIN; the pointer SHALL then increment by 1, wrapping from all-ones to 0; EXEC->DONE.
REQ-026 READ_RAM_H/L: VRAM_RD high for the EXEC cycle, with VRAM_ADDR = pointer; EXEC->RD_WAIT.
REQ-027 In RD_WAIT, the block SHALL count RD_LAT cycles from VRAM_RD, latch VRAM_RDATA into GP9001DOUT on the last count, then go to DONE.
REQ-028 READ_RAM_L SHALL increment the pointer (with wrap) on the latch cycle; READ_RAM_H SHALL leave the pointer unchanged.
REQ-029 GP9001ACK SHALL be high in DONE only.
REQ-030 DONE->IDLE SHALL occur on the first cycle GP9001CS is low.
REQ-031 A new request SHALL NOT be accepted before GP9001CS has been seen low (four-phase handshake).
REQ-032 GP9001DOUT SHALL hold its last latched value through non-read operations.
REQ-033 VRAM_ADDR SHALL continuously reflect the pointer outside strobe cycles.
REQ-034 Minimum latency from GP9001CS rise to ACK SHALL be 2 cycles for non-reads and 2+RD_LAT cycles for reads.
REQ-035 Changes to GP9001CS or the op flags during EXEC or RD_WAIT SHALL be ignored.
REQ-036 GP9001CS dropping before ACK SHALL NOT abort the operation; in that case DONE lasts one cycle, then IDLE.

Reset
REQ-037 RESET high SHALL asynchronously force state IDLE and drive GP9001ACK, REG_WE, VRAM_WE, VRAM_RD = 0.
REQ-038 RESET high SHALL also force REG_ADDR = 0, REG_DATA = 0, pointer/VRAM_ADDR = 0, VRAM_WDATA = 0, GP9001DOUT = 0, and the RD_WAIT counter = 0.
REQ-039 RESET mid-read SHALL discard the pending VRAM_RDATA, with no DOUT update and no pointer increment.
REQ-040 After RESET falls, the first request SHALL be accepted only if GP9001CS is high in IDLE.

Verification
REQ-041 SET_RAM_PTR with DIN=0x1234, then WRITE_RAM with DIN=0xBEEF -> VRAM_WE pulse at address 0x1234 with data 0xBEEF; pointer becomes 0x1235; ACK at cycle 2.
REQ-042 SET_RAM_PTR 0x3FFF, then WRITE_RAM -> write at 0x3FFF; pointer wraps to 0x0000.
REQ-043 With the pointer at 0x0100, model returning 0xA5A5: READ_RAM_H -> DOUT = 0xA5A5, pointer stays 0x0100; READ_RAM_L -> DOUT = 0xA5A5, pointer becomes 0x0101; ACK at cycle 2+RD_LAT.
REQ-044 SELECT_REG with DIN=0x0E, then WRITE_REG with DIN=0x00FF -> one REG_WE pulse with REG_ADDR = 0x0E and REG_DATA = 0x00FF; with GP9001CS held high 10 cycles after ACK, no second strobe.
REQ-045 SELECT_REG and WRITE_RAM set together -> only REG_ADDR is updated; no VRAM_WE; pointer unchanged.
REQ-046 RESET asserted in RD_WAIT -> ACK = 0, DOUT = 0, pointer = 0 immediately; the late VRAM_RDATA is ignored.
